// File: rtl/cr16_io_pkg.sv
// Shared constants for the CR16 memory-mapped I/O responder: register offsets,
// ID words and TIMER_CTRL bit positions.
package cr16_io_pkg;

    localparam logic [2:0] P_OFS_DISP_LO     = 3'd0;
    localparam logic [2:0] P_OFS_DISP_HI     = 3'd1;
    localparam logic [2:0] P_OFS_LEDS        = 3'd2;
    localparam logic [2:0] P_OFS_SWITCHES    = 3'd3;
    localparam logic [2:0] P_OFS_BTN_EVT     = 3'd4;
    localparam logic [2:0] P_OFS_TIMER_COUNT = 3'd5;
    localparam logic [2:0] P_OFS_TIMER_CTRL  = 3'd6;
    localparam logic [2:0] P_OFS_ID          = 3'd7;

    // Software tells the two builds apart by the low byte of the ID word.
    localparam logic [15:0] P_ID_TIMER    = 16'hC016;
    localparam logic [15:0] P_ID_NO_TIMER = 16'hC014;

    localparam int P_CTRL_EN_BIT  = 0;
    localparam int P_CTRL_CLR_BIT = 1;

    function automatic logic [15:0] zext10(input logic [9:0] v);
        return {6'd0, v};
    endfunction

endpackage

// File: rtl/cr16_io_sync.sv
// Two-flop synchronizer for slow asynchronous board inputs; 2-cycle latency,
// no backpressure. Resets to all zeros.
module cr16_io_sync #(
    parameter int P_WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_WIDTH-1:0] d,
    output logic [P_WIDTH-1:0] q
);

    logic [P_WIDTH-1:0] meta_q, meta_d;
    logic [P_WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/cr16_io_responder.sv
// CR16 external-memory I/O target: display, LEDs, switches, button events, ms timer
// (timer only with CR16_IO_TIMER_EN). Writes land on the hit edge, reads 1-cycle registered, no backpressure.
module cr16_io_responder
    import cr16_io_pkg::*;
#(
    parameter logic [15:0] P_BASE_ADDRESS   = 16'hFFF8,
    parameter logic [15:0] P_TIMER_PRESCALE = 16'd50000
) (
    input  logic        I_CLK,
    input  logic        I_NRESET,
    input  logic [15:0] I_EXT_MEM_ADDRESS,
    input  logic [15:0] I_EXT_MEM_DATA,
    input  logic        I_EXT_MEM_WRITE_ENABLE,
    output logic [15:0] O_EXT_MEM_DATA,
    input  logic [9:0]  I_SWITCHES,
    input  logic [3:0]  I_NBUTTONS,
    output logic [23:0] O_DISPLAY_BITS,
    output logic [9:0]  O_LEDS
);

    logic        hit;
    logic        wr;
    logic [2:0]  ofs;
    logic [9:0]  sw_s;
    logic [3:0]  nbtn_s;
    logic [3:0]  press;
    logic [3:0]  w1c_mask;

    logic [23:0] disp_q, disp_d;
    logic [9:0]  leds_q, leds_d;
    logic [3:0]  btn_dly_q, btn_dly_d;
    logic [3:0]  btn_evt_q, btn_evt_d;
    logic [15:0] rdata_q, rdata_d;

    logic [15:0] tmr_count_rd;
    logic [15:0] tmr_ctrl_rd;
    logic [15:0] id_rd;

    cr16_io_sync #(.P_WIDTH(10)) u_sync_sw (
        .clk   (I_CLK),
        .rst_n (I_NRESET),
        .d     (I_SWITCHES),
        .q     (sw_s)
    );

    cr16_io_sync #(.P_WIDTH(4)) u_sync_btn (
        .clk   (I_CLK),
        .rst_n (I_NRESET),
        .d     (I_NBUTTONS),
        .q     (nbtn_s)
    );

    assign hit = (I_EXT_MEM_ADDRESS[15:3] == P_BASE_ADDRESS[15:3]);
    assign ofs = I_EXT_MEM_ADDRESS[2:0];
    assign wr  = I_EXT_MEM_WRITE_ENABLE && hit;

`ifdef CR16_IO_TIMER_EN
    logic        tmr_en_q, tmr_en_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] tcount_q, tcount_d;

    always_comb begin
        tmr_en_d = tmr_en_q;
        presc_d  = presc_q;
        tcount_d = tcount_q;
        if (tmr_en_q) begin
            if (presc_q == P_TIMER_PRESCALE - 16'd1) begin
                presc_d  = 16'd0;
                tcount_d = tcount_q + 16'd1;
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
        // Clear is applied last so it overrides a tick on the same edge.
        if (wr && (ofs == P_OFS_TIMER_CTRL)) begin
            tmr_en_d = I_EXT_MEM_DATA[P_CTRL_EN_BIT];
            if (I_EXT_MEM_DATA[P_CTRL_CLR_BIT]) begin
                presc_d  = 16'd0;
                tcount_d = 16'd0;
            end
        end
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            tmr_en_q <= 1'b0;
            presc_q  <= 16'd0;
            tcount_q <= 16'd0;
        end else begin
            tmr_en_q <= tmr_en_d;
            presc_q  <= presc_d;
            tcount_q <= tcount_d;
        end
    end

    assign tmr_count_rd = tcount_q;
    assign tmr_ctrl_rd  = {15'd0, tmr_en_q};
    assign id_rd        = P_ID_TIMER;
`else
    assign tmr_count_rd = 16'h0000;
    assign tmr_ctrl_rd  = 16'h0000;
    assign id_rd        = P_ID_NO_TIMER;
`endif

    always_comb begin
        disp_d    = disp_q;
        leds_d    = leds_q;
        btn_dly_d = nbtn_s;
        // Press is the released-to-pressed transition of the active-low input.
        press     = btn_dly_q & ~nbtn_s;
        w1c_mask  = (wr && (ofs == P_OFS_BTN_EVT)) ? I_EXT_MEM_DATA[3:0] : 4'd0;
        btn_evt_d = (btn_evt_q & ~w1c_mask) | press;

        if (wr) begin
            case (ofs)
                P_OFS_DISP_LO: disp_d[15:0]  = I_EXT_MEM_DATA;
                P_OFS_DISP_HI: disp_d[23:16] = I_EXT_MEM_DATA[7:0];
                P_OFS_LEDS:    leds_d        = I_EXT_MEM_DATA[9:0];
                default:       ;
            endcase
        end

        // Read mux sees pre-write state, giving read-before-write.
        rdata_d = 16'h0000;
        if (hit) begin
            case (ofs)
                P_OFS_DISP_LO:     rdata_d = disp_q[15:0];
                P_OFS_DISP_HI:     rdata_d = {8'd0, disp_q[23:16]};
                P_OFS_LEDS:        rdata_d = zext10(leds_q);
                P_OFS_SWITCHES:    rdata_d = zext10(sw_s);
                P_OFS_BTN_EVT:     rdata_d = {12'd0, btn_evt_q};
                P_OFS_TIMER_COUNT: rdata_d = tmr_count_rd;
                P_OFS_TIMER_CTRL:  rdata_d = tmr_ctrl_rd;
                default:           rdata_d = id_rd;
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            disp_q    <= 24'd0;
            leds_q    <= 10'd0;
            btn_dly_q <= 4'd0;
            btn_evt_q <= 4'd0;
            rdata_q   <= 16'd0;
        end else begin
            disp_q    <= disp_d;
            leds_q    <= leds_d;
            btn_dly_q <= btn_dly_d;
            btn_evt_q <= btn_evt_d;
            rdata_q   <= rdata_d;
        end
    end

    assign O_EXT_MEM_DATA = rdata_q;
    assign O_DISPLAY_BITS = disp_q;
    assign O_LEDS         = leds_q;

endmodule

// File: tb/tb_cr16_io_responder.sv
// Scoreboarded bench for cr16_io_responder; timer checks run when CR16_IO_TIMER_EN is defined.
module tb_cr16_io_responder;

    localparam logic [15:0] BASE = 16'hFFF8;
`ifdef CR16_IO_TIMER_EN
    localparam logic [15:0] ID_EXP = 16'hC016;
`else
    localparam logic [15:0] ID_EXP = 16'hC014;
`endif

    logic        I_CLK = 1'b0;
    logic        I_NRESET = 1'b0;
    logic [15:0] I_EXT_MEM_ADDRESS = 16'd0;
    logic [15:0] I_EXT_MEM_DATA = 16'd0;
    logic        I_EXT_MEM_WRITE_ENABLE = 1'b0;
    logic [15:0] O_EXT_MEM_DATA;
    logic [9:0]  I_SWITCHES = 10'd0;
    logic [3:0]  I_NBUTTONS = 4'hF;
    logic [23:0] O_DISPLAY_BITS;
    logic [9:0]  O_LEDS;

    always #5 I_CLK = ~I_CLK;

    cr16_io_responder #(
        .P_BASE_ADDRESS   (BASE),
        .P_TIMER_PRESCALE (16'd4)
    ) dut (
        .I_CLK                  (I_CLK),
        .I_NRESET               (I_NRESET),
        .I_EXT_MEM_ADDRESS      (I_EXT_MEM_ADDRESS),
        .I_EXT_MEM_DATA         (I_EXT_MEM_DATA),
        .I_EXT_MEM_WRITE_ENABLE (I_EXT_MEM_WRITE_ENABLE),
        .O_EXT_MEM_DATA         (O_EXT_MEM_DATA),
        .I_SWITCHES             (I_SWITCHES),
        .I_NBUTTONS             (I_NBUTTONS),
        .O_DISPLAY_BITS         (O_DISPLAY_BITS),
        .O_LEDS                 (O_LEDS)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];
    logic        rd_mark = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus cycle: inputs change on the falling edge and are sampled on the next rising edge.
    task automatic cyc(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       input logic do_rd, input logic [15:0] exp, input string tag);
        @(negedge I_CLK);
        I_EXT_MEM_ADDRESS      = addr;
        I_EXT_MEM_DATA         = wd;
        I_EXT_MEM_WRITE_ENABLE = we;
        rd_mark                = do_rd;
        if (do_rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
    endtask

    task automatic wr(input logic [2:0] ofs, input logic [15:0] wd);
        cyc(1'b1, BASE | {13'd0, ofs}, wd, 1'b0, 16'd0, "");
    endtask

    task automatic rd(input logic [2:0] ofs, input logic [15:0] exp, input string tag);
        cyc(1'b0, BASE | {13'd0, ofs}, 16'd0, 1'b1, exp, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 16'd0, 1'b0, 16'd0, "");
    endtask

    always @(posedge I_CLK) begin
        if (rd_mark) begin
            #1;
            chk("sb_depth", exp_q.size(), 1);
            if (exp_q.size() != 0) chk(tag_q.pop_front(), O_EXT_MEM_DATA, exp_q.pop_front());
        end
    end

    initial begin
        #2;
        chk("rst_rdata", O_EXT_MEM_DATA, 16'h0000);
        chk("rst_disp", O_DISPLAY_BITS, 24'h0);
        chk("rst_leds", O_LEDS, 10'h0);
        repeat (2) @(negedge I_CLK);
        I_NRESET = 1'b1;

        rd(3'd7, ID_EXP, "id");
        idle(1);
        chk("disp_after_rst", O_DISPLAY_BITS, 24'h0);
        chk("leds_after_rst", O_LEDS, 10'h0);

        wr(3'd0, 16'hBEEF);
        wr(3'd1, 16'h12A5);
        idle(1);
        chk("disp_word", O_DISPLAY_BITS, 24'hA5BEEF);
        rd(3'd1, 16'h00A5, "disp_hi");
        rd(3'd0, 16'hBEEF, "disp_lo");

        wr(3'd2, 16'hFFFF);
        idle(1);
        chk("leds_all", O_LEDS, 10'h3FF);
        rd(3'd2, 16'h03FF, "leds_rd");

        // Read and write of the same register in one cycle returns the old value.
        cyc(1'b1, BASE | 16'd2, 16'h0055, 1'b1, 16'h03FF, "rbw_old");
        rd(3'd2, 16'h0055, "rbw_new");

        idle(1);
        I_SWITCHES = 10'h2AA;
        rd(3'd3, 16'h0000, "sw_early");
        rd(3'd3, 16'h02AA, "sw");

        cyc(1'b0, BASE - 16'd1, 16'd0, 1'b1, 16'h0000, "miss_rd");
        cyc(1'b1, BASE - 16'd1, 16'h1234, 1'b0, 16'd0, "");
        cyc(1'b1, 16'h0000, 16'h4321, 1'b0, 16'd0, "");
        cyc(1'b1, 16'h0002, 16'h0000, 1'b0, 16'd0, "");
        idle(1);
        chk("miss_disp", O_DISPLAY_BITS, 24'hA5BEEF);
        chk("miss_leds", O_LEDS, 10'h055);

        wr(3'd3, 16'hFFFF);
        rd(3'd3, 16'h02AA, "sw_ro");
        wr(3'd7, 16'h0000);
        rd(3'd7, ID_EXP, "id_ro");

        idle(1);
        I_NBUTTONS = 4'b1011;
        rd(3'd4, 16'h0000, "btn_e2");
        rd(3'd4, 16'h0000, "btn_e3");
        rd(3'd4, 16'h0004, "btn_set");
        I_NBUTTONS = 4'hF;
        idle(4);
        rd(3'd4, 16'h0004, "btn_sticky");

        idle(1);
        I_NBUTTONS = 4'b1011;
        idle(1);
        wr(3'd4, 16'h0004);
        rd(3'd4, 16'h0004, "btn_set_wins");
        I_NBUTTONS = 4'hF;
        idle(4);
        wr(3'd4, 16'h0004);
        rd(3'd4, 16'h0000, "btn_w1c");

`ifdef CR16_IO_TIMER_EN
        wr(3'd6, 16'h0001);
        idle(40);
        rd(3'd5, 16'd10, "tmr_10");
        rd(3'd6, 16'h0001, "tmr_ctrl");
        wr(3'd6, 16'h0003);
        rd(3'd5, 16'd0, "tmr_clr");
        rd(3'd6, 16'h0001, "tmr_still_en");
        idle(6);
        rd(3'd5, 16'd2, "tmr_after_clr");
        idle(2);
        wr(3'd6, 16'h0003);
        rd(3'd5, 16'd0, "tmr_clr_vs_tick");
        wr(3'd6, 16'h0000);
        idle(8);
        rd(3'd5, 16'd0, "tmr_hold");
        wr(3'd6, 16'h0001);
`else
        wr(3'd6, 16'h0001);
        rd(3'd6, 16'h0000, "no_tmr_ctrl");
        idle(8);
        rd(3'd5, 16'h0000, "no_tmr_count");
`endif

        wr(3'd2, 16'h0155);
        rd(3'd7, ID_EXP, "id_pre_rst");
        idle(1);
        I_NRESET = 1'b0;
        #1;
        chk("mid_rst_rdata", O_EXT_MEM_DATA, 16'h0000);
        chk("mid_rst_disp", O_DISPLAY_BITS, 24'h0);
        chk("mid_rst_leds", O_LEDS, 10'h0);
        @(negedge I_CLK);
        I_NRESET = 1'b1;
        idle(10);
        rd(3'd5, 16'h0000, "post_rst_count");
        rd(3'd6, 16'h0000, "post_rst_ctrl");
        rd(3'd2, 16'h0000, "post_rst_leds");
        idle(1);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge I_CLK);
        chk("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
